// File: rtl/m216a_pkg.sv
// Shared widths and types for the m216a multi-modulus divider.
package m216a_pkg;
  localparam int RATIO_W  = 4;
  localparam int NCNT_W   = 7;
  localparam int STAT_P_W = 16;
  localparam int STAT_S_W = 24;

  typedef logic [RATIO_W-1:0] ratio_t;
  typedef logic [NCNT_W-1:0]  ncnt_t;
endpackage

// File: rtl/m216a_mmd_stats.sv
// Saturating period counter and N accumulator for the divider.
// Instantiated only when M216A_MMD_STATS_EN is defined.
module m216a_mmd_stats
  import m216a_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                div_pulse,
  input  logic [NCNT_W-1:0]   n_cur,
  output logic [STAT_P_W-1:0] stat_periods,
  output logic [STAT_S_W-1:0] stat_sum
);
  localparam int SUM_EXT_W = STAT_S_W + 1;

  logic [STAT_P_W-1:0]  periods_q, periods_d;
  logic [STAT_S_W-1:0]  sum_q, sum_d;
  logic [SUM_EXT_W-1:0] sum_ext;

  always_comb begin
    periods_d = periods_q;
    sum_d     = sum_q;
    sum_ext   = {1'b0, sum_q} + SUM_EXT_W'(n_cur);
    if (div_pulse) begin
      if (periods_q != '1) periods_d = periods_q + STAT_P_W'(1);
      // The extra carry bit detects overflow so the sum sticks at all-ones.
      sum_d = sum_ext[STAT_S_W] ? '1 : sum_ext[STAT_S_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periods_q <= '0;
      sum_q     <= '0;
    end else begin
      periods_q <= periods_d;
      sum_q     <= sum_d;
    end
  end

  assign stat_periods = periods_q;
  assign stat_sum     = sum_q;
endmodule

// File: rtl/m216a_mmd_divider.sv
// Multi-modulus divider: each period lasts BASE + ratio clocks, one ratio drawn per period.
// Define M216A_MMD_STATS_EN to build the period/N statistics counters.
module m216a_mmd_divider
  import m216a_pkg::*;
#(
  parameter int BASE     = 16,
  parameter int REQ_LEAD = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RATIO_W-1:0]  ratio_in,
  input  logic                ratio_vld,
  output logic                ratio_req,
  output logic                div_pulse,
  output logic                div_clk,
  output logic                underrun,
  input  logic                underrun_clr,
  output logic [STAT_P_W-1:0] stat_periods,
  output logic [STAT_S_W-1:0] stat_sum
);
  localparam ncnt_t BASE_N = ncnt_t'(BASE);
  localparam ncnt_t LEAD_N = ncnt_t'(REQ_LEAD);
  localparam ncnt_t ONE_N  = ncnt_t'(1);

  ncnt_t  cnt_q, cnt_d;
  ncnt_t  n_cur_q, n_cur_d;
  ratio_t r_next_q, r_next_d;
  logic   have_next_q, have_next_d;
  logic   pend_q, pend_d;
  logic   underrun_q, underrun_d;
  logic   reload;
  ncnt_t  n_load;

  // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    cnt_d       = cnt_q - ONE_N;
    n_cur_d     = n_cur_q;
    r_next_d    = r_next_q;
    have_next_d = have_next_q;
    pend_d      = pend_q;
    underrun_d  = underrun_q;
    reload      = (cnt_q == '0);
    n_load      = BASE_N + ncnt_t'(r_next_q);

    if (underrun_clr) underrun_d = 1'b0;

    // A ratio arriving on the reload cycle is dropped; reload only sees registered state.
    if (pend_q && ratio_vld && !reload) begin
      r_next_d    = ratio_in;
      have_next_d = 1'b1;
      pend_d      = 1'b0;
    end

    if (cnt_q == LEAD_N) pend_d = 1'b1;

    if (reload) begin
      pend_d = 1'b0;
      if (have_next_q) begin
        n_cur_d     = n_load;
        cnt_d       = n_load - ONE_N;
        have_next_d = 1'b0;
      end else begin
        cnt_d      = n_cur_q - ONE_N;
        underrun_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= BASE_N - ONE_N;
      n_cur_q     <= BASE_N;
      r_next_q    <= '0;
      have_next_q <= 1'b0;
      pend_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      n_cur_q     <= n_cur_d;
      r_next_q    <= r_next_d;
      have_next_q <= have_next_d;
      pend_q      <= pend_d;
      underrun_q  <= underrun_d;
    end
  end

  assign div_pulse = (cnt_q == '0);
  assign div_clk   = (cnt_q >= (n_cur_q >> 1));
  assign ratio_req = (cnt_q == LEAD_N);
  assign underrun  = underrun_q;

`ifdef M216A_MMD_STATS_EN
  m216a_mmd_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_pulse    (div_pulse),
    .n_cur        (n_cur_q),
    .stat_periods (stat_periods),
    .stat_sum     (stat_sum)
  );
`else
  assign stat_periods = '0;
  assign stat_sum     = '0;
`endif
endmodule

// File: doc/m216a_mmd_divider.md
# m216a_mmd_divider

Programmable multi-modulus divider that consumes the 4-bit ratio stream from the MASH 1-1-1 delta-sigma modulator (`M216A_TopModule.out`). Each output period lasts `BASE + ratio` cycles of `clk`, so the long-run average division is `BASE + in_i + in_f/65536`. A request/valid handshake draws one new ratio per period. A sticky underrun flag reports any period that ran without a fresh ratio.

## Interface
- `BASE`, default 16: fixed offset added to the ratio; legal range 4..64.
- `REQ_LEAD`, default 2: `cnt` value at which `ratio_req` is issued; legal range 1..`BASE`-2.
- `clk  in  1`: divider input clock; this is the VCO clock in the system.
- `rst_n  in  1`: reset; active-low and asynchronous.
- `ratio_in  in  4`: next ratio, unsigned 0..15, driven by the modulator output.
- `ratio_vld  in  1`: `ratio_in` is valid this cycle.
- `ratio_req  out  1`: one-cycle request for the next ratio; this is the modulator advance enable.
- `div_pulse  out  1`: one-cycle pulse on the last cycle of each period.
- `div_clk  out  1`: divided clock, high for ceil(N/2) cycles of each N-cycle period.
- `underrun  out  1`: sticky; set when a period reloads without a captured ratio.
- `underrun_clr  in  1`: synchronous clear of `underrun`.
- `stat_periods  out  16`: number of completed periods (stats build only).
- `stat_sum  out  24`: sum of N over completed periods (stats build only).

## Operation
- State registers:
  - `cnt` is 7 bits and counts down.
  - `n_cur` is 7 bits and holds the current period length.
  - `r_next` is 4 bits and holds the captured ratio.
  - `have_next` marks a ratio captured for the next period.
  - `pend` marks an outstanding request.
- Period: `cnt` runs from `n_cur-1` down to 0, so each period is exactly `n_cur` cycles.
- Request:
  - When `cnt == REQ_LEAD`, `ratio_req` is 1 for one cycle and `pend` is set.
  - While `pend` is set, the first cycle with `ratio_vld` captures `ratio_in` into `r_next`, sets `have_next` and clears `pend`.
  - `ratio_vld` while `pend` is clear is ignored.
- Reload at `cnt == 0`:
  - If `have_next` is set: `n_cur <= BASE + r_next`, `cnt <= BASE + r_next - 1`, and `have_next` and `pend` are cleared.
  - If `have_next` is clear: `n_cur` is kept, `cnt <= n_cur - 1`, `underrun` is set, and `pend` is cleared.
- Capture and reload in the same cycle: a `ratio_vld` arriving while `cnt == 0` and `pend` is set is dropped and the cycle counts as an underrun. The capture path must not combinationally feed the reload.
- `underrun`:
  - `underrun_clr` clears it.
  - If a set (underrun at reload) and a clear occur in the same cycle, set wins.
- Widths: N = `BASE` + ratio is at most 79, so it fits in 7 bits. All N arithmetic is unsigned 7-bit with no wrap.
- Output decode uses registered state only; there is no combinational path from any input to any output.
  - `div_pulse = (cnt == 0)`.
  - `div_clk = (cnt >= n_cur >> 1)`.
  - `ratio_req = (cnt == REQ_LEAD)`.

## Timing
- Reset values:
  - `cnt = BASE-1`, `n_cur = BASE`, `r_next = 0`.
  - `have_next = 0`, `pend = 0`, `underrun = 0`.
  - All outputs are 0 except `div_clk = 1`, since `cnt >= BASE/2`.
- First edge after reset release: `cnt` begins counting down.
  - The first `ratio_req` comes `BASE-1-REQ_LEAD` cycles after release.
  - The first `div_pulse` comes `BASE-1` cycles after release.
- Handshake window: the upstream may answer `ratio_req` up to `REQ_LEAD-1` cycles later without underrun. The modulator responds in 1 cycle, so `REQ_LEAD >= 2`.
- New ratio latency: a ratio captured in period k sets the length of period k+1.
- Reset mid-period: reset asserted asynchronously forces all state to reset values immediately. No partial pulse is emitted.

## Configuration
- `M216A_MMD_STATS_EN` defined:
  - At each `div_pulse`, `stat_periods` increments and `stat_sum` adds `n_cur`.
  - Both saturate at all-ones and reset to 0.
  - The bench computes average N = `stat_sum` / `stat_periods`.
- `M216A_MMD_STATS_EN` undefined: both stat ports are tied to 0 and no counters are synthesized.

## Structure
- Package `m216a_pkg` holds:
  - `RATIO_W = 4`, `NCNT_W = 7`, `STAT_P_W = 16`, `STAT_S_W = 24`.
  - The typedef `ratio_t`.
- Sub-module `m216a_mmd_stats`:
  - Instantiated only under `M216A_MMD_STATS_EN`.
  - Inputs: `clk`, `rst_n`, `div_pulse`, `n_cur`.
  - Outputs: the two saturating counters.
- Counter, handshake and decode live in the top.

## Test plan
- Constant ratio: `ratio_in = 0`, `ratio_vld` returned 1 cycle after each `ratio_req`, `BASE = 16`.
  - Required: `div_pulse` spacing is exactly 16; `div_clk` is high 8 and low 8; `underrun = 0`.
- Constant ratio 7: required `div_pulse` spacing is 23 and `div_clk` is high 12, low 11.
- Ratio sequence 3, 0, 15, 5:
  - Required: period lengths 19, 16, 31, 21, each one period after capture.
  - With stats enabled: `stat_sum = 87` and `stat_periods = 4` after those four periods.
- Underrun: hold `ratio_vld = 0` for one period.
  - Required: that period repeats the previous N and `underrun` goes to 1 and stays 1.
  - `underrun_clr` then returns it to 0.
  - Set and clear in the same cycle leaves it at 1.
- Reset mid-period: assert `rst_n = 0` at `cnt = 5` while N = 23.
  - Required: all outputs reset at once.
  - After release, the first `div_pulse` arrives exactly 15 cycles later.
- Closed loop with `M216A_TopModule`, `in_i = 7`, `in_f = 32768`, over 5000 periods.
  - Required: mean N = 23.5 ± 0.01 and no underrun.
